// File: rtl/ccip_mem_responder_if.sv
// CCI-P request/response bundle between afu_top (master) and the memory-side
// responder (slave), including the bench throttle control and status outputs.
interface ccip_mem_responder_if;
    logic         afu_tx_rd_valid;
    logic [41:0]  afu_tx_rd_addr;
    logic [15:0]  afu_tx_rd_mdata;
    logic         afu_tx_wr_valid;
    logic [41:0]  afu_tx_wr_addr;
    logic [15:0]  afu_tx_wr_mdata;
    logic [511:0] afu_tx_data;
    logic         rsp_throttle;

    logic         spl_tx_rd_almostfull;
    logic         spl_tx_wr_almostfull;
    logic         spl_rx_rd_valid;
    logic [15:0]  spl_rx_rd_mdata;
    logic [511:0] spl_rx_data;
    logic         spl_rx_wr_valid;
    logic [15:0]  spl_rx_wr_mdata;
    logic         overflow_err;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    modport master (
        output afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        output afu_tx_wr_valid, afu_tx_wr_addr, afu_tx_wr_mdata, afu_tx_data,
        output rsp_throttle,
        input  spl_tx_rd_almostfull, spl_tx_wr_almostfull,
        input  spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        input  spl_rx_wr_valid, spl_rx_wr_mdata,
        input  overflow_err, rd_count, wr_count
    );

    modport slave (
        input  afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        input  afu_tx_wr_valid, afu_tx_wr_addr, afu_tx_wr_mdata, afu_tx_data,
        input  rsp_throttle,
        output spl_tx_rd_almostfull, spl_tx_wr_almostfull,
        output spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        output spl_rx_wr_valid, spl_rx_wr_mdata,
        output overflow_err, rd_count, wr_count
    );
endinterface

// File: rtl/ccip_mem_responder.sv
// Memory-side CCI-P responder: per-channel request FIFOs serviced from a local
// line-addressed RAM, with fixed-latency read responses and write acks.
module ccip_mem_responder #(
    parameter int MEM_AW      = 10,
    parameter int FIFO_DEPTH  = 32,
    parameter int AFULL_SLACK = 8,
    parameter int RD_LATENCY  = 4
) (
    input logic                 clk,
    input logic                 spl_reset,
    ccip_mem_responder_if.slave bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NSTG = RD_LATENCY - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - AFULL_SLACK);

    logic [511:0]      mem_q [2**MEM_AW];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [511:0]      mem_wdata;

    logic [MEM_AW-1:0] rdf_addr_q  [FIFO_DEPTH];
    logic [15:0]       rdf_mdata_q [FIFO_DEPTH];
    logic [PW-1:0]     rdf_wptr_q, rdf_wptr_d;
    logic [PW-1:0]     rdf_rptr_q, rdf_rptr_d;
    logic [CW-1:0]     rdf_cnt_q, rdf_cnt_d;
    logic              rd_push, rd_pop;

    logic [MEM_AW-1:0] wdf_addr_q  [FIFO_DEPTH];
    logic [15:0]       wdf_mdata_q [FIFO_DEPTH];
    logic [511:0]      wdf_data_q  [FIFO_DEPTH];
    logic [PW-1:0]     wdf_wptr_q, wdf_wptr_d;
    logic [PW-1:0]     wdf_rptr_q, wdf_rptr_d;
    logic [CW-1:0]     wdf_cnt_q, wdf_cnt_d;
    logic              wr_push, wr_pop;

    logic              rd_afull_q, rd_afull_d;
    logic              wr_afull_q, wr_afull_d;
    logic              ovf_q, ovf_d;

    // Stage 0 holds the RAM read result; the last stage drives the response.
    logic [NSTG-1:0]   pipe_vld_q, pipe_vld_d;
    logic [15:0]       pipe_mdata_q [NSTG];
    logic [15:0]       pipe_mdata_d [NSTG];
    logic [511:0]      pipe_data_q  [NSTG];
    logic [511:0]      pipe_data_d  [NSTG];

    logic              wr_rsp_vld_q, wr_rsp_vld_d;
    logic [15:0]       wr_rsp_mdata_q, wr_rsp_mdata_d;
    logic [31:0]       rd_rsp_cnt_q, rd_rsp_cnt_d;
    logic [31:0]       wr_rsp_cnt_q, wr_rsp_cnt_d;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.afu_tx_rd_addr[41:MEM_AW], bus.afu_tx_wr_addr[41:MEM_AW]};

    // Full check uses pre-pop occupancy, so push+pop on a full FIFO still drops.
    always_comb begin
        rd_push    = bus.afu_tx_rd_valid && (rdf_cnt_q != DEPTH_C);
        rd_pop     = (rdf_cnt_q != '0) && !bus.rsp_throttle;
        wr_push    = bus.afu_tx_wr_valid && (wdf_cnt_q != DEPTH_C);
        wr_pop     = (wdf_cnt_q != '0) && !bus.rsp_throttle;

        rdf_wptr_d = rdf_wptr_q + PW'(rd_push);
        rdf_rptr_d = rdf_rptr_q + PW'(rd_pop);
        rdf_cnt_d  = rdf_cnt_q + CW'(rd_push) - CW'(rd_pop);
        wdf_wptr_d = wdf_wptr_q + PW'(wr_push);
        wdf_rptr_d = wdf_rptr_q + PW'(wr_pop);
        wdf_cnt_d  = wdf_cnt_q + CW'(wr_push) - CW'(wr_pop);

        rd_afull_d = (rdf_cnt_d >= AFULL_C);
        wr_afull_d = (wdf_cnt_d >= AFULL_C);
        ovf_d      = ovf_q
                   | (bus.afu_tx_rd_valid && (rdf_cnt_q == DEPTH_C))
                   | (bus.afu_tx_wr_valid && (wdf_cnt_q == DEPTH_C));
    end

    always_comb begin
        mem_we         = wr_pop && !spl_reset;
        mem_waddr      = wdf_addr_q[wdf_rptr_q];
        mem_wdata      = wdf_data_q[wdf_rptr_q];
        wr_rsp_vld_d   = wr_pop;
        wr_rsp_mdata_d = wr_pop ? wdf_mdata_q[wdf_rptr_q] : '0;

        // Reading mem_q here registers the old line when a write commits in the same cycle.
        pipe_vld_d      = '0;
        pipe_vld_d[0]   = rd_pop;
        pipe_mdata_d[0] = rd_pop ? rdf_mdata_q[rdf_rptr_q] : '0;
        pipe_data_d[0]  = rd_pop ? mem_q[rdf_addr_q[rdf_rptr_q]] : '0;
        for (int k = 1; k < NSTG; k++) begin
            pipe_vld_d[k]   = pipe_vld_q[k-1];
            pipe_mdata_d[k] = pipe_mdata_q[k-1];
            pipe_data_d[k]  = pipe_data_q[k-1];
        end

        rd_rsp_cnt_d = rd_rsp_cnt_q + 32'(pipe_vld_q[NSTG-1]);
        wr_rsp_cnt_d = wr_rsp_cnt_q + 32'(wr_rsp_vld_q);
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            rdf_addr_q[rdf_wptr_q]  <= bus.afu_tx_rd_addr[MEM_AW-1:0];
            rdf_mdata_q[rdf_wptr_q] <= bus.afu_tx_rd_mdata;
        end
        if (wr_push) begin
            wdf_addr_q[wdf_wptr_q]  <= bus.afu_tx_wr_addr[MEM_AW-1:0];
            wdf_mdata_q[wdf_wptr_q] <= bus.afu_tx_wr_mdata;
            wdf_data_q[wdf_wptr_q]  <= bus.afu_tx_data;
        end
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (spl_reset) begin
            rdf_wptr_q     <= '0;
            rdf_rptr_q     <= '0;
            rdf_cnt_q      <= '0;
            wdf_wptr_q     <= '0;
            wdf_rptr_q     <= '0;
            wdf_cnt_q      <= '0;
            rd_afull_q     <= 1'b0;
            wr_afull_q     <= 1'b0;
            ovf_q          <= 1'b0;
            pipe_vld_q     <= '0;
            for (int k = 0; k < NSTG; k++) begin
                pipe_mdata_q[k] <= '0;
                pipe_data_q[k]  <= '0;
            end
            wr_rsp_vld_q   <= 1'b0;
            wr_rsp_mdata_q <= '0;
            rd_rsp_cnt_q   <= '0;
            wr_rsp_cnt_q   <= '0;
        end else begin
            rdf_wptr_q     <= rdf_wptr_d;
            rdf_rptr_q     <= rdf_rptr_d;
            rdf_cnt_q      <= rdf_cnt_d;
            wdf_wptr_q     <= wdf_wptr_d;
            wdf_rptr_q     <= wdf_rptr_d;
            wdf_cnt_q      <= wdf_cnt_d;
            rd_afull_q     <= rd_afull_d;
            wr_afull_q     <= wr_afull_d;
            ovf_q          <= ovf_d;
            pipe_vld_q     <= pipe_vld_d;
            pipe_mdata_q   <= pipe_mdata_d;
            pipe_data_q    <= pipe_data_d;
            wr_rsp_vld_q   <= wr_rsp_vld_d;
            wr_rsp_mdata_q <= wr_rsp_mdata_d;
            rd_rsp_cnt_q   <= rd_rsp_cnt_d;
            wr_rsp_cnt_q   <= wr_rsp_cnt_d;
        end
    end

    assign bus.spl_tx_rd_almostfull = rd_afull_q;
    assign bus.spl_tx_wr_almostfull = wr_afull_q;
    assign bus.spl_rx_rd_valid      = pipe_vld_q[NSTG-1];
    assign bus.spl_rx_rd_mdata      = pipe_mdata_q[NSTG-1];
    assign bus.spl_rx_data          = pipe_data_q[NSTG-1];
    assign bus.spl_rx_wr_valid      = wr_rsp_vld_q;
    assign bus.spl_rx_wr_mdata      = wr_rsp_mdata_q;
    assign bus.overflow_err         = ovf_q;
    assign bus.rd_count             = rd_rsp_cnt_q;
    assign bus.wr_count             = wr_rsp_cnt_q;
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Self-checking bench for ccip_mem_responder: directed scenarios followed by
// randomized traffic compared against a line-array memory model.
module tb_ccip_mem_responder;
    localparam int MEM_AW      = 10;
    localparam int FIFO_DEPTH  = 32;
    localparam int AFULL_SLACK = 8;
    localparam int RD_LATENCY  = 4;
    localparam int LINES       = 1 << MEM_AW;

    logic clk = 1'b0;
    logic spl_reset;
    ccip_mem_responder_if bus();

    ccip_mem_responder #(
        .MEM_AW(MEM_AW), .FIFO_DEPTH(FIFO_DEPTH),
        .AFULL_SLACK(AFULL_SLACK), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .spl_reset(spl_reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           rd_cyc_q[$];
    logic [15:0]  rd_md_q[$];
    logic [511:0] rd_dat_q[$];
    int           wr_cyc_q[$];
    logic [15:0]  wr_md_q[$];

    always @(negedge clk) begin
        if (bus.spl_rx_rd_valid === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            rd_md_q.push_back(bus.spl_rx_rd_mdata);
            rd_dat_q.push_back(bus.spl_rx_data);
        end
        if (bus.spl_rx_wr_valid === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_md_q.push_back(bus.spl_rx_wr_mdata);
        end
    end

    logic [511:0] model_mem [LINES];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        rd_cyc_q.delete(); rd_md_q.delete(); rd_dat_q.delete();
        wr_cyc_q.delete(); wr_md_q.delete();
    endtask

    task automatic drive_rd(input logic [41:0] a, input logic [15:0] m);
        bus.afu_tx_rd_valid = 1'b1;
        bus.afu_tx_rd_addr  = a;
        bus.afu_tx_rd_mdata = m;
    endtask

    task automatic drive_wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
        bus.afu_tx_wr_valid = 1'b1;
        bus.afu_tx_wr_addr  = a;
        bus.afu_tx_wr_mdata = m;
        bus.afu_tx_data     = d;
    endtask

    task automatic release_req();
        bus.afu_tx_rd_valid = 1'b0;
        bus.afu_tx_wr_valid = 1'b0;
    endtask

    function automatic int line_of(input logic [41:0] a);
        return int'(a % 42'(LINES));
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] pat_a5, dat_a, dat_b, d;
        logic [41:0]  addr;
        logic [15:0]  md;
        int t0, t1, r, g, stall_hit, ln;
        int           wl[$];
        logic [15:0]  exp_md[$];
        logic [511:0] exp_dat[$];

        pat_a5 = {64{8'hA5}};
        stall_hit = 0;
        bus.afu_tx_rd_valid = 1'b0; bus.afu_tx_rd_addr = '0; bus.afu_tx_rd_mdata = '0;
        bus.afu_tx_wr_valid = 1'b0; bus.afu_tx_wr_addr = '0; bus.afu_tx_wr_mdata = '0;
        bus.afu_tx_data = '0; bus.rsp_throttle = 1'b0;
        spl_reset = 1'b1;
        idle(3);
        spl_reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_afull", 512'(bus.spl_tx_rd_almostfull), 512'(0));
        chk("rst_wr_afull", 512'(bus.spl_tx_wr_almostfull), 512'(0));
        chk("rst_rd_valid", 512'(bus.spl_rx_rd_valid), 512'(0));
        chk("rst_wr_valid", 512'(bus.spl_rx_wr_valid), 512'(0));
        chk("rst_rd_mdata", 512'(bus.spl_rx_rd_mdata), 512'(0));
        chk("rst_wr_mdata", 512'(bus.spl_rx_wr_mdata), 512'(0));
        chk("rst_data", bus.spl_rx_data, 512'(0));
        chk("rst_ovf", 512'(bus.overflow_err), 512'(0));
        chk("rst_rd_count", 512'(bus.rd_count), 512'(0));
        chk("rst_wr_count", 512'(bus.wr_count), 512'(0));
        tick();

        // Basic write then read latency
        drive_wr(42'h5, 16'h11, pat_a5);
        model_mem[line_of(42'h5)] = pat_a5;
        t0 = cyc;
        tick(); release_req();
        tick();
        drive_rd(42'h5, 16'h22);
        t1 = cyc;
        tick(); release_req();
        idle(8);
        exp_wr_cnt += 1; exp_rd_cnt += 1;
        chk("t1_wr_n", 512'(wr_cyc_q.size()), 512'(1));
        chk("t1_rd_n", 512'(rd_cyc_q.size()), 512'(1));
        if (wr_cyc_q.size() >= 1) begin
            chk("t1_wr_lat", 512'(wr_cyc_q[0]), 512'(t0 + 2));
            chk("t1_wr_md", 512'(wr_md_q[0]), 512'(16'h11));
        end
        if (rd_cyc_q.size() >= 1) begin
            chk("t1_rd_lat", 512'(rd_cyc_q[0]), 512'(t1 + RD_LATENCY));
            chk("t1_rd_md", 512'(rd_md_q[0]), 512'(16'h22));
            chk("t1_rd_data", rd_dat_q[0], model_mem[5]);
        end
        chk("t1_rd_count", 512'(bus.rd_count), 512'(exp_rd_cnt));
        chk("t1_wr_count", 512'(bus.wr_count), 512'(exp_wr_cnt));
        clear_mon();

        // Throttled reads up to the almost-full threshold
        bus.rsp_throttle = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive_rd({32'($urandom), 10'h005}, 16'(16'h100 + i));
            tick();
            if (i == 23) release_req();
            @(negedge clk);
            chk("t2_afull_fill", 512'(bus.spl_tx_rd_almostfull), 512'(i >= 23));
        end
        chk("t2_ovf", 512'(bus.overflow_err), 512'(0));
        tick();
        bus.rsp_throttle = 1'b0;
        r = cyc;
        @(negedge clk);
        chk("t2_afull_hold", 512'(bus.spl_tx_rd_almostfull), 512'(1));
        tick();
        @(negedge clk);
        chk("t2_afull_fall", 512'(bus.spl_tx_rd_almostfull), 512'(0));
        idle(40);
        exp_rd_cnt += 24;
        chk("t2_rd_n", 512'(rd_cyc_q.size()), 512'(24));
        for (int i = 0; i < rd_cyc_q.size() && i < 24; i++) begin
            chk("t2_rd_md", 512'(rd_md_q[i]), 512'(16'h100 + i));
            chk("t2_rd_data", rd_dat_q[i], model_mem[5]);
            chk("t2_rd_cyc", 512'(rd_cyc_q[i]), 512'(r + RD_LATENCY - 1 + i));
        end
        chk("t2_rd_count", 512'(bus.rd_count), 512'(exp_rd_cnt));
        clear_mon();

        // Write FIFO overflow
        bus.rsp_throttle = 1'b1;
        for (int i = 0; i < 33; i++) begin
            d = rand_line();
            addr = {32'($urandom), 10'(10'h040 + i)};
            drive_wr(addr, 16'(16'h200 + i), d);
            if (i < 32) model_mem[line_of(addr)] = d;
            tick();
        end
        release_req();
        @(negedge clk);
        chk("t3_ovf_set", 512'(bus.overflow_err), 512'(1));
        chk("t3_wr_afull", 512'(bus.spl_tx_wr_almostfull), 512'(1));
        tick();
        bus.rsp_throttle = 1'b0;
        idle(50);
        exp_wr_cnt += 32;
        chk("t3_wr_n", 512'(wr_cyc_q.size()), 512'(32));
        for (int i = 0; i < wr_cyc_q.size() && i < 32; i++)
            chk("t3_wr_md", 512'(wr_md_q[i]), 512'(16'h200 + i));
        chk("t3_ovf_sticky", 512'(bus.overflow_err), 512'(1));
        chk("t3_wr_count", 512'(bus.wr_count), 512'(exp_wr_cnt));
        clear_mon();

        // Address aliasing
        d = rand_line();
        drive_wr(42'h405, 16'h33, d);
        model_mem[line_of(42'h405)] = d;
        tick(); release_req();
        idle(2);
        drive_rd(42'h5, 16'h44);
        tick(); release_req();
        idle(8);
        exp_wr_cnt += 1; exp_rd_cnt += 1;
        chk("t4_rd_n", 512'(rd_cyc_q.size()), 512'(1));
        if (rd_cyc_q.size() >= 1) begin
            chk("t4_rd_md", 512'(rd_md_q[0]), 512'(16'h44));
            chk("t4_alias_data", rd_dat_q[0], model_mem[5]);
        end
        clear_mon();

        // Same-cycle write commit vs read of the same line
        dat_a = rand_line();
        dat_b = rand_line();
        drive_wr(42'h7, 16'h50, dat_a);
        model_mem[7] = dat_a;
        tick(); release_req();
        idle(4);
        drive_wr(42'h7, 16'h55, dat_b);
        drive_rd(42'h7, 16'h66);
        t0 = cyc;
        tick();
        bus.afu_tx_wr_valid = 1'b0;
        model_mem[7] = dat_b;
        drive_rd(42'h7, 16'h77);
        tick(); release_req();
        idle(8);
        exp_wr_cnt += 2; exp_rd_cnt += 2;
        chk("t5_rd_n", 512'(rd_cyc_q.size()), 512'(2));
        chk("t5_wr_n", 512'(wr_cyc_q.size()), 512'(2));
        if (rd_cyc_q.size() >= 2) begin
            chk("t5_old_md", 512'(rd_md_q[0]), 512'(16'h66));
            chk("t5_old_data", rd_dat_q[0], dat_a);
            chk("t5_old_cyc", 512'(rd_cyc_q[0]), 512'(t0 + RD_LATENCY));
            chk("t5_new_md", 512'(rd_md_q[1]), 512'(16'h77));
            chk("t5_new_data", rd_dat_q[1], model_mem[7]);
            chk("t5_new_cyc", 512'(rd_cyc_q[1]), 512'(t0 + 1 + RD_LATENCY));
        end
        chk("t5_rd_count", 512'(bus.rd_count), 512'(exp_rd_cnt));
        chk("t5_wr_count", 512'(bus.wr_count), 512'(exp_wr_cnt));
        clear_mon();

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) begin
            drive_rd(42'h5, 16'(16'h90 + i));
            tick();
        end
        release_req();
        spl_reset = 1'b1;
        tick();
        spl_reset = 1'b0;
        drive_rd(42'h5, 16'hAB);
        t0 = cyc;
        exp_rd_cnt = 0; exp_wr_cnt = 0;
        @(negedge clk);
        chk("t6_rd_count0", 512'(bus.rd_count), 512'(0));
        chk("t6_wr_count0", 512'(bus.wr_count), 512'(0));
        chk("t6_rd_afull0", 512'(bus.spl_tx_rd_almostfull), 512'(0));
        chk("t6_wr_afull0", 512'(bus.spl_tx_wr_almostfull), 512'(0));
        chk("t6_ovf0", 512'(bus.overflow_err), 512'(0));
        tick(); release_req();
        idle(8);
        exp_rd_cnt += 1;
        chk("t6_rd_n", 512'(rd_cyc_q.size()), 512'(1));
        if (rd_cyc_q.size() >= 1) begin
            chk("t6_rd_md", 512'(rd_md_q[0]), 512'(16'hAB));
            chk("t6_rd_cyc", 512'(rd_cyc_q[0]), 512'(t0 + RD_LATENCY));
            chk("t6_rd_data", rd_dat_q[0], model_mem[5]);
        end
        chk("t6_rd_count", 512'(bus.rd_count), 512'(exp_rd_cnt));
        clear_mon();

        // Random writes with random throttle, honouring almost-full
        for (int i = 0; i < 40; i++) begin
            g = 0;
            while (bus.spl_tx_wr_almostfull === 1'b1 && g < 200) begin
                bus.rsp_throttle = 1'b0;
                tick();
                g++;
            end
            if (g >= 200) stall_hit = 1;
            bus.rsp_throttle = ($urandom_range(0, 3) == 0);
            addr = {32'($urandom), 10'($urandom_range(0, LINES - 1))};
            d = rand_line();
            md = 16'($urandom);
            drive_wr(addr, md, d);
            model_mem[line_of(addr)] = d;
            wl.push_back(line_of(addr));
            exp_md.push_back(md);
            tick(); release_req();
            repeat ($urandom_range(0, 2)) begin
                bus.rsp_throttle = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        bus.rsp_throttle = 1'b0;
        idle(80);
        exp_wr_cnt += 40;
        chk("t7_wr_n", 512'(wr_cyc_q.size()), 512'(40));
        for (int i = 0; i < wr_cyc_q.size() && i < 40; i++)
            chk("t7_wr_md", 512'(wr_md_q[i]), 512'(exp_md[i]));
        chk("t7_wr_count", 512'(bus.wr_count), 512'(exp_wr_cnt));
        clear_mon();
        exp_md.delete();

        // Random reads of written lines against the model
        for (int i = 0; i < 40; i++) begin
            g = 0;
            while (bus.spl_tx_rd_almostfull === 1'b1 && g < 200) begin
                bus.rsp_throttle = 1'b0;
                tick();
                g++;
            end
            if (g >= 200) stall_hit = 1;
            bus.rsp_throttle = ($urandom_range(0, 3) == 0);
            ln = wl[$urandom_range(0, wl.size() - 1)];
            addr = {32'($urandom), 10'(ln)};
            md = 16'($urandom);
            drive_rd(addr, md);
            exp_md.push_back(md);
            exp_dat.push_back(model_mem[ln]);
            tick(); release_req();
            repeat ($urandom_range(0, 2)) begin
                bus.rsp_throttle = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        bus.rsp_throttle = 1'b0;
        idle(80);
        exp_rd_cnt += 40;
        chk("t8_rd_n", 512'(rd_cyc_q.size()), 512'(40));
        for (int i = 0; i < rd_cyc_q.size() && i < 40; i++) begin
            chk("t8_rd_md", 512'(rd_md_q[i]), 512'(exp_md[i]));
            chk("t8_rd_data", rd_dat_q[i], exp_dat[i]);
        end
        chk("t8_rd_count", 512'(bus.rd_count), 512'(exp_rd_cnt));
        chk("t8_no_stall", 512'(stall_hit), 512'(0));
        chk("t8_ovf", 512'(bus.overflow_err), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ccip_mem_responder.md
Name: ccip_mem_responder

Overview:
- Memory-side responder for the CCI-P read/write request ports driven by afu_top.
- Accepts AFU read and write requests into per-channel request FIFOs and services them from a local line-addressed RAM.
- Returns read responses carrying data and mdata, and write responses carrying mdata. Drives the almost-full flow control the AFU honours.
- Replaces the FIU/MPF path in block-level simulation and in on-FPGA loopback builds of afu_top.

Parameters:
- MEM_AW, 10, log2 of the RAM depth in 512-bit lines; the request address is truncated to its low MEM_AW bits.
- FIFO_DEPTH, 32, entries per request FIFO; power of two, at least 8.
- AFULL_SLACK, 8, almost-full asserts when occupancy is at least FIFO_DEPTH-AFULL_SLACK.
- RD_LATENCY, 4, cycles from an accepted read request to its response when the FIFO is empty; at least 3.

Ports:
- clk  in  1  single clock for all logic
- spl_reset  in  1  synchronous active-high reset
- afu_tx_rd_valid  in  1  read request strobe
- afu_tx_rd_addr  in  42  read cache-line address
- afu_tx_rd_mdata  in  16  read request tag
- afu_tx_wr_valid  in  1  write request strobe
- afu_tx_wr_addr  in  42  write cache-line address
- afu_tx_wr_mdata  in  16  write request tag
- afu_tx_data  in  512  write data
- rsp_throttle  in  1  bench control; while high, neither FIFO is popped
- spl_tx_rd_almostfull  out  1  read FIFO almost-full
- spl_tx_wr_almostfull  out  1  write FIFO almost-full
- spl_rx_rd_valid  out  1  read response strobe
- spl_rx_rd_mdata  out  16  tag of the read response
- spl_rx_data  out  512  read response data
- spl_rx_wr_valid  out  1  write response strobe
- spl_rx_wr_mdata  out  16  tag of the write response
- overflow_err  out  1  sticky: a request arrived while its FIFO was full
- rd_count  out  32  read responses issued
- wr_count  out  32  write responses issued

Behaviour:
- Reset (spl_reset high at a clk edge) clears:
  - both FIFOs and the read pipeline;
  - all valid outputs, overflow_err, rd_count and wr_count;
  - both almost-full outputs; spl_rx_data and both mdata outputs go to 0.
- Reset does not clear RAM contents.
- A reset asserted mid-operation discards in-flight requests, and no response is emitted for them. The first post-reset request is accepted in the cycle after reset deasserts.
- Request acceptance:
  - A valid request in cycle T is written into its FIFO at the edge ending T.
  - Requests are never refused. If the FIFO is full, the request is dropped and overflow_err sets and stays set until reset.
  - The AFU must honour almost-full; AFULL_SLACK covers its in-flight requests.
- Almost-full is registered and reflects the occupancy after the current cycle's push and pop.
- Pop rule: each FIFO pops at most one entry per cycle when it is non-empty and rsp_throttle is 0. Read and write FIFOs pop independently in the same cycle.
- Write path:
  - A popped write commits afu_tx_data to RAM[addr[MEM_AW-1:0]].
  - spl_rx_wr_valid pulses one cycle later with that entry's mdata.
  - With an empty FIFO, the write response appears exactly 2 cycles after the request cycle.
- Read path:
  - A popped read issues a RAM read. The result travels through a delay pipeline so that spl_rx_rd_valid, mdata and data appear RD_LATENCY-1 cycles after the pop.
  - With an empty FIFO and no throttle, the response appears exactly RD_LATENCY cycles after the request cycle.
- Ordering:
  - Responses within a channel come out in request order.
  - No ordering holds across channels.
  - A read popped in the same cycle as a write commit to the same line returns the old data.
  - A read popped in any later cycle returns the new data.
- Throttle: rsp_throttle stops pops only. Reads already popped still complete on schedule.
- Addresses alias modulo 2^MEM_AW lines; the upper address bits are ignored.
- Counters increment on each response valid and wrap from 2^32-1 to 0.
- Simultaneous push and pop on a full FIFO is a drop; the full check uses occupancy before the pop.
- Simultaneous push and pop on an empty FIFO is legal: the entry is pushed, and popped no earlier than the next cycle.

Test Plan:
- Write addr 0x5, mdata 0x11, data all-0xA5, idle, then read addr 0x5, mdata 0x22 -> spl_rx_wr_valid 2 cycles after the write with mdata 0x11; spl_rx_rd_valid exactly 4 cycles after the read with mdata 0x22 and data all-0xA5.
- Hold rsp_throttle high and issue 24 reads -> spl_tx_rd_almostfull rises on the cycle after the 24th request is accepted and overflow_err stays 0. Release throttle -> 24 responses in request order, rd_count=24, almost-full falls once occupancy drops below 24.
- Throttle high, 33 writes -> the 33rd is dropped, overflow_err=1 and sticky. Release -> exactly 32 write responses, wr_count=32.
- Write addr 0x405 with MEM_AW=10, then read addr 0x5 -> the read returns the written data (aliasing).
- Same-cycle pop of a write to line 7 (new data B, old A) and a read of line 7 -> read data A; a read of line 7 issued on the next cycle -> B.
- Assert spl_reset for 1 cycle with 3 reads in flight -> no responses for them, counters 0, almost-full 0; a new read 1 cycle later responds in 4 cycles.
